// File: rtl/serial2parallel_align.sv
// Receive-side deserializer: shifts in one bit per clock, locks onto the K28.5
// comma and hands aligned 10-bit symbols with a valid strobe to the 8b10b decoder.
module serial2parallel_align #(
   parameter logic [9:0] COMMA_NEG    = 10'b0011111010,
   parameter logic [9:0] COMMA_POS    = 10'b1100000101,
   parameter int         SYNC_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_1b,
   output logic [9:0] out_10b,
   output logic       valid,
   output logic       aligned,
   output logic       comma_det,
   output logic       realign
);

   typedef enum logic {HUNT, SYNC} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(SYNC_TIMEOUT);

   state_t     state_q, state_d;
   logic [9:0] shreg_q, shreg_d;
   logic [9:0] out_q, out_d;
   logic       valid_q, valid_d;
   logic       commaDet_q, commaDet_d;
   logic       realign_q, realign_d;
   logic [3:0] phase_q, phase_d;
   logic [7:0] tcnt_q, tcnt_d;
   logic [7:0] tcntInc;
   logic       isComma;

   // Synchronous reset drops any partially received symbol along with the lock.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= HUNT;
         shreg_q    <= '0;
         out_q      <= '0;
         valid_q    <= 1'b0;
         commaDet_q <= 1'b0;
         realign_q  <= 1'b0;
         phase_q    <= '0;
         tcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         out_q      <= out_d;
         valid_q    <= valid_d;
         commaDet_q <= commaDet_d;
         realign_q  <= realign_d;
         phase_q    <= phase_d;
         tcnt_q     <= tcnt_d;
      end
   end

   // Comma detection runs on the window that includes the bit arriving this edge.
   always_comb begin
      shreg_d    = {shreg_q[8:0], in_1b};
      isComma    = (shreg_d == COMMA_NEG) || (shreg_d == COMMA_POS);
      tcntInc    = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
      state_d    = state_q;
      out_d      = out_q;
      valid_d    = 1'b0;
      commaDet_d = 1'b0;
      realign_d  = 1'b0;
      phase_d    = phase_q;
      tcnt_d     = tcnt_q;

      unique case (state_q)
         HUNT: begin
            if (isComma) begin
               out_d      = shreg_d;
               valid_d    = 1'b1;
               commaDet_d = 1'b1;
               phase_d    = '0;
               tcnt_d     = '0;
               state_d    = SYNC;
            end
         end
         SYNC: begin
            if (phase_q == 4'd9) begin
               out_d      = shreg_d;
               valid_d    = 1'b1;
               commaDet_d = isComma;
               phase_d    = '0;
               if (isComma) begin
                  tcnt_d = '0;
               end else begin
                  tcnt_d = tcntInc;
                  // A boundary symbol that exhausts the comma budget is still delivered.
                  if ((SYNC_TIMEOUT != 0) && (tcntInc == TIMEOUT_CNT)) begin
                     state_d = HUNT;
                  end
               end
            end else if (isComma) begin
               out_d      = shreg_d;
               valid_d    = 1'b1;
               commaDet_d = 1'b1;
               realign_d  = 1'b1;
               phase_d    = '0;
               tcnt_d     = '0;
            end else begin
               phase_d = phase_q + 4'd1;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   assign out_10b   = out_q;
   assign valid     = valid_q;
   assign comma_det = commaDet_q;
   assign realign   = realign_q;
   assign aligned   = (state_q == SYNC);

endmodule
